// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM states and sync-character geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } ab_state_t;

    // 0x55 framed LSB first: five falling edges spanning eight bit periods
    localparam int SYNC_FALL_EDGES       = 5;
    localparam int SYNC_BIT_PERIODS_LOG2 = 3;

endpackage

// File: rtl/uart_edge_detector.sv
// Registered falling-edge detector; every pulse lags its line edge by one cycle.
module uart_edge_detector #(
    parameter int BUS_WIDTH = 1
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [BUS_WIDTH-1:0] i_data,
    output logic [BUS_WIDTH-1:0] o_fall
);

    logic [BUS_WIDTH-1:0] hist_q;
    logic [BUS_WIDTH-1:0] fall_q;

    // History register and one-cycle falling-edge pulse
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            hist_q <= '0;
            fall_q <= '0;
        end else begin
            hist_q <= i_data;
            fall_q <= hist_q & ~i_data;
        end
    end

    assign o_fall = fall_q;

endmodule

// File: rtl/uart_autobaud.sv
// UART baud-rate measurement on a 0x55 sync character.
// Optional interval consistency check: UART_AUTOBAUD_CONSISTENCY_CHECK_EN.
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int CNT_W       = 20,
    parameter int OVS_LOG2    = 4,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_rx,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [CNT_W-1:0] o_divider
);

    localparam int               SHIFT   = SYNC_BIT_PERIODS_LOG2 + OVS_LOG2;
    localparam logic [CNT_W:0]   ROUND   = {{CNT_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ab_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       edges_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic [CNT_W-1:0] divider_q;

    logic             fall_d;
    logic [CNT_W:0]   divider_d;
    logic             intv_bad_d;

    uart_edge_detector #(
        .BUS_WIDTH (1)
    ) u_edge (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_data (i_rx),
        .o_fall (fall_d)
    );

    // In DONE cnt_q holds M; the extra bit keeps the rounding add from overflowing
    assign divider_d = ({1'b0, cnt_q} + ROUND) >> SHIFT;

`ifdef UART_AUTOBAUD_CONSISTENCY_CHECK_EN
    logic [CNT_W:0] i1_q;
    logic [CNT_W:0] mark_q;
    logic [CNT_W:0] stamp_d;
    logic [CNT_W:0] intv_d;
    logic [CNT_W:0] tol_d;

    assign stamp_d = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign intv_d  = stamp_d - mark_q;
    assign tol_d   = i1_q >> 2;
    // The tolerance band edges count as inconsistent; an exact match never does
    assign intv_bad_d = (edges_q >= 3'd2) && (intv_d != i1_q) &&
                        ((intv_d >= i1_q + tol_d) || (intv_d <= i1_q - tol_d));

    // Reference interval and timestamp of the previous falling edge
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            i1_q   <= '0;
            mark_q <= '0;
        end else if (state_q == WAIT_EDGE && fall_d) begin
            mark_q <= '0;
        end else if (state_q == MEASURE && fall_d) begin
            if (edges_q == 3'd1) begin
                i1_q <= intv_d;
            end
            mark_q <= stamp_d;
        end
    end
`else
    assign intv_bad_d = 1'b0;
`endif

    // Measurement FSM with registered status outputs and divider
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            edges_q   <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            divider_q <= CNT_W'(DEFAULT_DIV);
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (i_abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
                edges_q <= 3'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_start) begin
                            state_q <= WAIT_EDGE;
                            busy_q  <= 1'b1;
                        end
                    end
                    WAIT_EDGE: begin
                        if (fall_d) begin
                            state_q <= MEASURE;
                            cnt_q   <= '0;
                            edges_q <= 3'd1;
                        end
                    end
                    MEASURE: begin
                        if (cnt_q == CNT_MAX) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else if (fall_d && intv_bad_d) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            // Counting through the final edge makes cnt_q equal M in DONE
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (fall_d) begin
                                edges_q <= edges_q + 3'd1;
                                if (edges_q == 3'(SYNC_FALL_EDGES - 1)) begin
                                    state_q <= DONE;
                                end
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (divider_d != '0) begin
                            divider_q <= divider_d[CNT_W-1:0];
                            done_q    <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_error   = error_q;
    assign o_divider = divider_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: randomized sync frames against a divider model.
module tb_uart_autobaud;

    localparam int OVS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst, rx_drv, start_drv, abort_drv, sel8;
    logic busy0, done0, err0, busy8, done8, err8;
    logic [19:0] div0;
    logic [7:0]  div8;

    uart_autobaud dut (
        .i_clk(clk), .i_nrst(nrst),
        .i_rx(sel8 ? 1'b1 : rx_drv), .i_start(sel8 ? 1'b0 : start_drv),
        .i_abort(sel8 ? 1'b0 : abort_drv),
        .o_busy(busy0), .o_done(done0), .o_error(err0), .o_divider(div0)
    );

    uart_autobaud #(.CNT_W(8)) dut8 (
        .i_clk(clk), .i_nrst(nrst),
        .i_rx(sel8 ? rx_drv : 1'b1), .i_start(sel8 ? start_drv : 1'b0),
        .i_abort(sel8 ? abort_drv : 1'b0),
        .o_busy(busy8), .o_done(done8), .o_error(err8), .o_divider(div8)
    );

    wire        busy_s = sel8 ? busy8 : busy0;
    wire        done_s = sel8 ? done8 : done0;
    wire        err_s  = sel8 ? err8  : err0;
    wire [19:0] div_s  = sel8 ? {12'd0, div8} : div0;

    int cyc = 0;
    int n_done = 0, n_err = 0, n_both = 0, last_done_cyc = 0, last_err_cyc = 0;
    int n_checks = 0, n_fail = 0;
    int per [10];
    int falls [$];
    logic [7:0] sync = 8'h55;
    int exp0 = 1, exp8 = 1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_s) begin n_done <= n_done + 1; last_done_cyc <= cyc; end
        if (err_s)  begin n_err  <= n_err + 1;  last_err_cyc  <= cyc; end
        if ((done0 && err0) || (done8 && err8)) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: divider from the sum of the eight bit periods between edges 1 and 5
    function automatic int model_div(input int m, input int cntw);
        int d;
        if (m >= (1 << cntw)) return -1;
        d = (m + (1 << (2 + OVS))) >> (3 + OVS);
        return (d == 0) ? -1 : d;
    endfunction

    task automatic pulse_start();
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
    endtask

    // Drives start, 0x55 LSB first, stop; called at a negedge
    task automatic send_frame(input int nbits, input bit poke);
        falls.delete();
        for (int b = 0; b < nbits; b++) begin
            logic lvl;
            lvl = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : sync[b-1]);
            if (rx_drv && !lvl) falls.push_back(cyc);
            rx_drv = lvl;
            for (int k = 0; k < per[b]; k++) begin
                @(negedge clk);
                start_drv = (poke && b == 5 && k == 0);
            end
        end
        start_drv = 1'b0;
    endtask

    task automatic measure(input string tag, input bit poke, input bit force_fail);
        int m, d, bd, be, lat;
        m = 0;
        for (int b = 0; b < 8; b++) m += per[b];
        d = force_fail ? -1 : model_div(m, sel8 ? 8 : 20);
        bd = n_done;
        be = n_err;
        pulse_start();
        check({tag, "_busy"}, busy_s, 1);
        send_frame(10, poke);
        repeat (4) @(negedge clk);
        check({tag, "_done"}, n_done - bd, (d > 0) ? 1 : 0);
        check({tag, "_err"}, n_err - be, (d > 0) ? 0 : 1);
        if (d > 0) begin
            if (sel8) exp8 = d; else exp0 = d;
        end
        check({tag, "_div"}, div_s, sel8 ? exp8 : exp0);
        lat = ((d > 0) ? last_done_cyc : last_err_cyc) - falls[4];
        check({tag, "_lat"}, lat, 3);
        check({tag, "_idle"}, busy_s, 0);
    endtask

    task automatic set_per(input int p);
        for (int b = 0; b < 10; b++) per[b] = p;
    endtask

    initial begin
        int bd, be, fall_c, p;
        nrst = 1'b0; rx_drv = 1'b1; start_drv = 1'b0; abort_drv = 1'b0; sel8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_div", div0, 1);
        check("rst_div8", div8, 1);
        nrst = 1'b1;
        repeat (5) @(negedge clk);

        set_per(160); measure("p160", 0, 0);
        set_per(167); measure("p167", 0, 0);
        set_per(7);   measure("p7_zero", 0, 0);
        set_per(8);   measure("p8_min", 0, 0);
        for (int i = 0; i < 10; i++) begin
            p = $urandom_range(4, 200);
            for (int b = 0; b < 10; b++) per[b] = p + $urandom_range(0, p / 16);
            measure("rand", 0, 0);
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        // Abort after the third falling edge
        set_per(160);
        bd = n_done; be = n_err;
        pulse_start();
        send_frame(5, 0);
        abort_drv = 1'b1;
        @(negedge clk);
        abort_drv = 1'b0;
        check("abort_busy", busy0, 0);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_done", n_done - bd, 0);
        check("abort_err", n_err - be, 0);
        check("abort_div", div0, exp0);
        set_per(100); measure("post_abort", 0, 0);

        // Reset mid-measurement
        set_per(100);
        pulse_start();
        send_frame(4, 0);
        nrst = 1'b0;
        @(negedge clk);
        check("mrst_busy", busy0, 0);
        check("mrst_done", done0, 0);
        check("mrst_err", err0, 0);
        check("mrst_div", div0, 1);
        exp0 = 1; exp8 = 1;
        rx_drv = 1'b1;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        check("mrst_idle", busy0, 0);
        measure("after_rst", 1, 0);

        // One stretched bit period
        per = '{160, 160, 160, 160, 240, 160, 160, 160, 160, 160};
`ifdef UART_AUTOBAUD_CONSISTENCY_CHECK_EN
        measure("irregular", 0, 1);
`else
        measure("irregular", 0, 0);
`endif

        // Narrow counter instance: a good run, then counter saturation
        sel8 = 1'b1;
        repeat (5) @(negedge clk);
        set_per(30); measure("c8_ok", 0, 0);
        bd = n_done; be = n_err;
        pulse_start();
        fall_c = cyc;
        rx_drv = 1'b0;
        repeat (30) @(negedge clk);
        rx_drv = 1'b1;
        for (int k = 0; k < 400 && n_err == be; k++) @(negedge clk);
        @(negedge clk);
        check("ovf_err", n_err - be, 1);
        check("ovf_done", n_done - bd, 0);
        check("ovf_time", last_err_cyc - fall_c, 258);
        check("ovf_div", div8, exp8);
        check("ovf_idle", busy8, 0);

        check("done_err_overlap", n_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_autobaud.md
UART_AUTOBAUD -- requirements
Module: uart_autobaud

Interface
REQ-001 The block SHALL have parameter CNT_W, default 20, giving the measurement counter width in bits.
REQ-002 The block SHALL have parameter OVS_LOG2, default 4, giving log2 of the receiver oversampling factor.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 1, giving the o_divider value after reset.
REQ-004 The block SHALL have i_clk  input  1  clock, with all logic on the rising edge.
REQ-005 The block SHALL have i_nrst  input  1  reset: asynchronous, active-low.
REQ-006 The block SHALL have i_rx  input  1  RX line, already synchronised to i_clk, idle high.
REQ-007 The block SHALL have i_start  input  1  single-cycle request to begin a measurement.
REQ-008 The block SHALL have i_abort  input  1  cancels any measurement in progress.
REQ-009 The block SHALL have o_busy  output  1  high when the state is not IDLE.
REQ-010 The block SHALL have o_done  output  1  one-cycle pulse when a valid divider has been latched.
REQ-011 The block SHALL have o_error  output  1  one-cycle pulse when a measurement fails.
REQ-012 The block SHALL have o_divider  output  CNT_W  last valid baud divider, held between measurements.

Function
REQ-013 The block SHALL use sync character 0x55, sent LSB first; on the line this gives falling edges at start, bit1, bit3, bit5 and bit7, i.e. 5 falling edges spanning 8 bit periods.
REQ-014 The block SHALL implement states IDLE, WAIT_EDGE, MEASURE and DONE.
- IDLE -> WAIT_EDGE on i_start.
- WAIT_EDGE -> MEASURE on the first falling-edge pulse; the counter clears to 0 and the edge count becomes 1.
- MEASURE counts cycles; each falling-edge pulse increments the edge count; the fifth pulse moves to DONE.
- DONE -> IDLE after exactly one cycle.
REQ-015 M SHALL be the number of i_clk cycles between the first and fifth falling-edge pulses (pulses at cycles 10 and 1290 give M = 1280).
REQ-016 The divider SHALL be computed in DONE as (M + 2^(2+OVS_LOG2)) >> (3+OVS_LOG2), using round-to-nearest, in CNT_W+1-bit arithmetic with no overflow.
REQ-017 If the computed divider is non-zero, the block SHALL latch it to o_divider and pulse o_done in the cycle after DONE.
REQ-018 If the computed divider is zero, the block SHALL pulse o_error and leave o_divider unchanged.
REQ-019 If the counter reaches 2^CNT_W-1 in MEASURE, the block SHALL pulse o_error one cycle later, return to IDLE, and leave o_divider unchanged.
REQ-020 WAIT_EDGE SHALL have no timeout; only i_abort or reset leave it without an edge.
REQ-021 i_abort SHALL force IDLE on the next cycle from any state, with no o_done or o_error pulse, and SHALL take priority over a simultaneous edge or i_start.
REQ-022 i_start SHALL be ignored while o_busy is high.
REQ-023 Rising edges on i_rx SHALL be ignored, and o_done and o_error SHALL never be high in the same cycle.

Reset
REQ-024 While i_nrst is low, the block SHALL hold state IDLE, the counter and edge count at 0, o_busy/o_done/o_error at 0, o_divider at DEFAULT_DIV, and the edge detector history at 0.
REQ-025 A reset asserted mid-measurement SHALL discard the measurement; after release the block SHALL be idle and require a new i_start.

Configuration
REQ-026 With UART_AUTOBAUD_CONSISTENCY_CHECK_EN defined, the block SHALL record I1 (first-to-second falling edge interval) and check each later falling-to-falling interval against it; any interval outside I1 ± (I1 >> 2) SHALL give o_error at the end of that interval and return to IDLE.
REQ-027 Without UART_AUTOBAUD_CONSISTENCY_CHECK_EN, the block SHALL contain no interval registers or comparators, and only REQ-016/018/019 SHALL decide success.

Structure
REQ-028 The state enum type, SYNC_FALL_EDGES = 5 and SYNC_BIT_PERIODS_LOG2 = 3 SHALL live in shared package uart_pkg.
REQ-029 Falling edges SHALL come from one uart_edge_detector instance with BUS_WIDTH = 1 driven by i_rx; its one-cycle latency applies equally to every edge, so M is unaffected.

Verification
REQ-030 Defaults: i_start, then 0x55 at 160 cycles/bit -> M = 1280; o_done one cycle after DONE; o_divider = 10.
REQ-031 Defaults: 0x55 at 167 cycles/bit -> M = 1336, (1336 + 64) >> 7 = 10; o_divider = 10, confirming rounding.
REQ-032 CNT_W = 8: one falling edge, then line held high -> o_error once the counter reaches 255; o_divider keeps its previous value.
REQ-033 i_abort after the third falling edge -> IDLE next cycle, no o_done/o_error, o_divider unchanged; a following full 0x55 measurement succeeds.
REQ-034 i_nrst asserted during MEASURE -> all outputs at reset values and o_divider = DEFAULT_DIV; i_start pulsed while busy in a later run has no effect.
REQ-035 With the macro defined: bit periods 160,160,160,160,240,160,160,160 -> o_error; the same stream without the macro -> o_done.
